contador_regresivo: RTL and testbench
=====================================

CONTADOR_REGRESIVO -- requirements
Module: contador_regresivo

Interface
REQ-001 Parameter COUNTER_MAX, default 'd9: largest loadable count value, inclusive.
REQ-002 Parameter TICK_DIV, default 'd1: clock cycles per count step while running; TICK_DIV >= 1.
REQ-003 Localparam N = $clog2(COUNTER_MAX+1): count width; COUNTER_MAX itself SHALL be representable.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load  input  1  load load_value into the counter this cycle.
REQ-007 load_value  input  N  value to load.
REQ-008 start  input  1  begin or resume counting down.
REQ-009 pause  input  1  freeze counting while running.
REQ-010 contador  output  N  current count, registered.
REQ-011 busy  output  1  high in RUN or PAUSED.
REQ-012 done  output  1  one-cycle pulse when the count reaches zero.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, RUN, PAUSED, DONE.
REQ-014 load SHALL take priority over start and pause in every state: contador <= min(load_value, COUNTER_MAX), state -> IDLE, prescaler cleared.
REQ-015 In IDLE, start with contador != 0 SHALL move to RUN; start with contador == 0 SHALL move to DONE.
REQ-016 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and assert an internal tick in the cycle it reaches TICK_DIV-1, then wrap to 0.
REQ-017 Each tick in RUN SHALL decrement contador by 1; a tick with contador == 1 SHALL set contador to 0 and state to DONE.
REQ-018 With TICK_DIV = 1, the first decrement SHALL occur on the first rising edge after RUN is entered; a load of K SHALL reach 0 exactly K*TICK_DIV cycles after entering RUN.
REQ-019 In RUN, pause SHALL move to PAUSED and beat a coincident tick: no decrement that cycle, prescaler held.
REQ-020 In PAUSED, contador and prescaler SHALL hold; start SHALL return to RUN with the prescaler resuming from its held value; pause is ignored.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, contador SHALL stay 0, and the next state SHALL be IDLE unless load is asserted.
REQ-022 start asserted in RUN and start/pause asserted in DONE SHALL be ignored.
REQ-023 Simultaneous start and pause in IDLE or PAUSED SHALL act as start.
REQ-024 contador SHALL never wrap below 0 or exceed COUNTER_MAX.
REQ-025 busy and done SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-026 reset SHALL take priority over all inputs, including load.
REQ-027 On reset: state IDLE, contador 0, prescaler 0, busy 0, done 0, effective at the next rising edge.
REQ-028 reset asserted mid-count SHALL abort counting with no done pulse.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, RUN, PAUSED, DONE).
REQ-030 The prescaler SHALL be a sub-module, divisor_tick, with ports clk, reset, enable, clear and tick, parameterised by TICK_DIV.
REQ-031 Expected implementation size: 120-400 RTL lines including the sub-module.

Verification
REQ-032 TICK_DIV=1; load 3, then start -> contador 3,2,1,0 on successive edges, done high exactly one cycle, then IDLE, busy low.
REQ-033 TICK_DIV=4; load 2, start -> each decrement 4 cycles apart, done 8 cycles after entering RUN.
REQ-034 TICK_DIV=1; load 5, start, pause on the cycle contador=3 for 5 cycles, then start -> holds 3 through pause, resumes 2,1,0, done once.
REQ-035 COUNTER_MAX=9; load 15 -> contador 9; start with contador 0 -> DONE immediately, done pulse, contador stays 0.
REQ-036 load 7 while RUN at contador=4 -> contador 7, state IDLE, busy 0, no done.
REQ-037 reset during RUN at contador=2 -> contador 0, busy 0, done never asserted.

Source files
------------

// File: rtl/contador_regresivo_pkg.sv
// Shared types for the down-counter: FSM state encoding.
package contador_regresivo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } estado_t;

endpackage

// File: rtl/contador_regresivo_divisor_tick.sv
// Prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the last one as a tick.
module divisor_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  // Tick is seen in the same cycle the count sits at LAST, so the owner acts on that edge.
  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/contador_regresivo.sv
// Loadable down-counter with start/pause control, prescaled step rate and a done pulse.
module contador_regresivo
  import contador_regresivo_pkg::*;
#(
  parameter int COUNTER_MAX = 'd9,
  parameter int TICK_DIV    = 'd1,
  localparam int N          = $clog2(COUNTER_MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         pause,
  output logic [N-1:0] contador,
  output logic         busy,
  output logic         done
);

  localparam logic [N-1:0] CMAX = N'(COUNTER_MAX);

  estado_t      state_q, state_d;
  logic [N-1:0] cont_q, cont_d;
  logic         tick, pre_en, pre_clr;

  // Pause or load in RUN freezes the prescaler for that cycle; outside RUN/PAUSED it sits at zero.
  assign pre_en  = (state_q == RUN) && !pause && !load;
  assign pre_clr = load || ((state_q != RUN) && (state_q != PAUSED));

  divisor_tick #(.TICK_DIV(TICK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    if (load) begin
      cont_d  = (load_value > CMAX) ? CMAX : load_value;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = (cont_q == '0) ? DONE : RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (cont_q <= N'(1)) begin
              cont_d  = '0;
              state_d = DONE;
            end else begin
              cont_d = cont_q - 1'b1;
            end
          end
        end
        PAUSED: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          cont_d  = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cont_q  <= '0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
    end
  end

  assign contador = cont_q;
  assign busy     = (state_q == RUN) || (state_q == PAUSED);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_contador_regresivo.sv
// Directed bench for contador_regresivo: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_contador_regresivo;

  logic       clk = 1'b0;
  logic       reset;
  logic       load1, start1, pause1, load4, start4, pause4;
  logic [3:0] lv1, lv4, cont1, cont4;
  logic       busy1, done1, busy4, done4;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  contador_regresivo #(.COUNTER_MAX(9), .TICK_DIV(1)) dut (
    .clk(clk), .reset(reset), .load(load1), .load_value(lv1), .start(start1),
    .pause(pause1), .contador(cont1), .busy(busy1), .done(done1)
  );

  contador_regresivo #(.COUNTER_MAX(9), .TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .load(load4), .load_value(lv4), .start(start4),
    .pause(pause4), .contador(cont4), .busy(busy4), .done(done4)
  );

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_dut1(input logic [3:0] v);
    load1 = 1'b1; lv1 = v;
    step();
    load1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load1 = 1'b1; lv1 = 4'd5; load4 = 1'b1; lv4 = 4'd6;
    step(); step();
    tests++;
    if (cont1 !== 4'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++; $display("FAIL reset_dut1 got cont=%0d busy=%b done=%b exp 0/0/0", cont1, busy1, done1);
    end
    tests++;
    if (cont4 !== 4'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      fails++; $display("FAIL reset_dut4 got cont=%0d busy=%b done=%b exp 0/0/0", cont4, busy4, done4);
    end
    reset = 1'b0; load1 = 1'b0; load4 = 1'b0;
  endtask

  task automatic test_countdown();
    logic [3:0] exp_c [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
    logic       exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_d [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    load_dut1(4'd3);
    tests++;
    if (cont1 !== 4'd3 || busy1 !== 1'b0) begin
      fails++; $display("FAIL cd_load got cont=%0d busy=%b exp 3/0", cont1, busy1);
    end
    start1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start1 = 1'b0;
      tests++;
      if (cont1 !== exp_c[i] || busy1 !== exp_b[i] || done1 !== exp_d[i]) begin
        fails++;
        $display("FAIL cd_step%0d got cont=%0d busy=%b done=%b exp %0d/%b/%b",
                 i, cont1, busy1, done1, exp_c[i], exp_b[i], exp_d[i]);
      end
    end
    step();
    tests++;
    if (cont1 !== 4'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++; $display("FAIL cd_idle got cont=%0d busy=%b done=%b exp 0/0/0", cont1, busy1, done1);
    end
  endtask

  task automatic test_tickdiv4();
    logic [3:0] e;
    load4 = 1'b1; lv4 = 4'd2;
    step();
    load4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    tests++;
    if (cont4 !== 4'd2 || busy4 !== 1'b1) begin
      fails++; $display("FAIL td4_run got cont=%0d busy=%b exp 2/1", cont4, busy4);
    end
    for (int c = 1; c <= 9; c++) begin
      step();
      e = (c < 4) ? 4'd2 : (c < 8) ? 4'd1 : 4'd0;
      tests++;
      if (cont4 !== e || done4 !== (c == 8)) begin
        fails++;
        $display("FAIL td4_cyc%0d got cont=%0d done=%b exp %0d/%b", c, cont4, done4, e, (c == 8));
      end
    end
    tests++;
    if (busy4 !== 1'b0) begin
      fails++; $display("FAIL td4_idle got busy=%b exp 0", busy4);
    end
  endtask

  task automatic test_pause();
    int npulse = 0;
    load_dut1(4'd5);
    start1 = 1'b1; step(); start1 = 1'b0;
    step(); step();
    tests++;
    if (cont1 !== 4'd3) begin
      fails++; $display("FAIL pz_pre got cont=%0d exp 3", cont1);
    end
    pause1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (cont1 !== 4'd3 || busy1 !== 1'b1 || done1 !== 1'b0) begin
        fails++; $display("FAIL pz_hold%0d got cont=%0d busy=%b done=%b exp 3/1/0", i, cont1, busy1, done1);
      end
    end
    start1 = 1'b1;  // start together with pause resumes
    step();
    start1 = 1'b0; pause1 = 1'b0;
    tests++;
    if (cont1 !== 4'd3 || busy1 !== 1'b1) begin
      fails++; $display("FAIL pz_resume got cont=%0d busy=%b exp 3/1", cont1, busy1);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (done1) npulse++;
      if (i < 3) begin
        tests++;
        if (cont1 !== 4'(2 - i)) begin
          fails++; $display("FAIL pz_dec%0d got cont=%0d exp %0d", i, cont1, 2 - i);
        end
      end
    end
    tests++;
    if (npulse != 1) begin
      fails++; $display("FAIL pz_done_count got %0d exp 1", npulse);
    end
  endtask

  task automatic test_clamp_zero_start();
    load_dut1(4'd15);
    tests++;
    if (cont1 !== 4'd9) begin
      fails++; $display("FAIL clamp got cont=%0d exp 9", cont1);
    end
    load_dut1(4'd0);
    start1 = 1'b1; step(); start1 = 1'b0;
    tests++;
    if (cont1 !== 4'd0 || done1 !== 1'b1 || busy1 !== 1'b0) begin
      fails++; $display("FAIL zero_start got cont=%0d done=%b busy=%b exp 0/1/0", cont1, done1, busy1);
    end
    step();
    tests++;
    if (cont1 !== 4'd0 || done1 !== 1'b0) begin
      fails++; $display("FAIL zero_after got cont=%0d done=%b exp 0/0", cont1, done1);
    end
  endtask

  task automatic test_load_override();
    int npulse = 0;
    load_dut1(4'd6);
    start1 = 1'b1; step(); start1 = 1'b0;
    step(); step();
    tests++;
    if (cont1 !== 4'd4 || busy1 !== 1'b1) begin
      fails++; $display("FAIL lo_pre got cont=%0d busy=%b exp 4/1", cont1, busy1);
    end
    load_dut1(4'd7);
    tests++;
    if (cont1 !== 4'd7 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++; $display("FAIL lo_load got cont=%0d busy=%b done=%b exp 7/0/0", cont1, busy1, done1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (done1) npulse++;
    end
    tests++;
    if (cont1 !== 4'd7 || npulse != 0) begin
      fails++; $display("FAIL lo_hold got cont=%0d pulses=%0d exp 7/0", cont1, npulse);
    end
  endtask

  task automatic test_reset_mid();
    int npulse = 0;
    load_dut1(4'd4);
    start1 = 1'b1; step(); start1 = 1'b0;
    step(); step();
    tests++;
    if (cont1 !== 4'd2) begin
      fails++; $display("FAIL rm_pre got cont=%0d exp 2", cont1);
    end
    reset = 1'b1; load1 = 1'b1; lv1 = 4'd8;  // reset outranks load
    step();
    reset = 1'b0; load1 = 1'b0;
    if (done1) npulse++;
    tests++;
    if (cont1 !== 4'd0 || busy1 !== 1'b0) begin
      fails++; $display("FAIL rm_reset got cont=%0d busy=%b exp 0/0", cont1, busy1);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (done1) npulse++;
    end
    tests++;
    if (npulse != 0 || cont1 !== 4'd0) begin
      fails++; $display("FAIL rm_nodone got pulses=%0d cont=%0d exp 0/0", npulse, cont1);
    end
  endtask

  task automatic test_start_held();
    // start held throughout: ignored in RUN and DONE, then restarts from IDLE with count 0
    load_dut1(4'd2);
    start1 = 1'b1;
    step(); step(); step();
    tests++;
    if (cont1 !== 4'd0 || done1 !== 1'b1) begin
      fails++; $display("FAIL sh_done got cont=%0d done=%b exp 0/1", cont1, done1);
    end
    step();
    tests++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      fails++; $display("FAIL sh_idle got done=%b busy=%b exp 0/0", done1, busy1);
    end
    step();
    tests++;
    if (done1 !== 1'b1 || cont1 !== 4'd0) begin
      fails++; $display("FAIL sh_redone got done=%b cont=%0d exp 1/0", done1, cont1);
    end
    start1 = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0;
    load1 = 1'b0; start1 = 1'b0; pause1 = 1'b0; lv1 = '0;
    load4 = 1'b0; start4 = 1'b0; pause4 = 1'b0; lv4 = '0;
    test_reset();
    test_countdown();
    test_tickdiv4();
    test_pause();
    test_clamp_zero_start();
    test_load_override();
    test_reset_mid();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
